// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss, streams one aligned block from main memory
// into the cache data array, then writes the tag. fsm_busy stalls the pipeline meanwhile.
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    localparam int IDX_W          = $clog2(WORDS_PER_BLOCK),
    localparam int OFF_W          = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              memory_enable,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  fill_word_index,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDX_W:0]     issue_cnt_q;
    logic [IDX_W-1:0]   recv_cnt_q;
    logic [ADDR_W-1:0]  base_addr_q;
    logic               in_fill;
    logic               last_word;

    // The receive side only counts valids, so the memory latency never enters the logic;
    // a memory returning data while requests are still being issued is handled as is.
    if (MEM_LATENCY < 1) begin : g_latency_note
    end

    // Handshake: memory_enable is a one-cycle read request with no back-pressure; memory
    // answers each request, in order, with one memory_data_valid cycle some cycles later.
    assign in_fill          = (state_q == FILL);
    assign fsm_busy         = in_fill;
    assign memory_enable    = in_fill && (issue_cnt_q < (IDX_W+1)'(WORDS_PER_BLOCK));
    assign memory_address   = in_fill ? {base_addr_q[ADDR_W-1:OFF_W], issue_cnt_q[IDX_W-1:0], 1'b0}
                                      : '0;
    assign write_data_array = in_fill && memory_data_valid;
    assign fill_word_index  = recv_cnt_q;
    assign fill_data        = memory_data;
    assign last_word        = (recv_cnt_q == IDX_W'(WORDS_PER_BLOCK - 1));
    assign write_tag_array  = write_data_array && last_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_detected) begin
                        state_q     <= FILL;
                        // Aligned base: offset bits are rebuilt from issue_cnt, so no carry into the tag.
                        base_addr_q <= {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end
                end
                FILL: begin
                    if (memory_enable) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                    if (memory_data_valid) begin
                        recv_cnt_q <= recv_cnt_q + 1'b1;
                        if (last_word) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a 3-stage memory model answers requests, stimulus pushes
// expected issues/writes/busy lengths, and a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic          memory_data_valid;
    logic [DW-1:0] memory_data;
    logic          fsm_busy;
    logic          memory_enable;
    logic [AW-1:0] memory_address;
    logic          write_data_array;
    logic [IW-1:0] fill_word_index;
    logic [DW-1:0] fill_data;
    logic          write_tag_array;

    logic [AW-1:0]      exp_addr_q[$];
    logic [DW+IW:0]     exp_wr_q[$];
    int                 exp_busy_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic          inj_valid = 1'b0;
    logic [DW-1:0] inj_data  = '0;
    logic          hist_en[3];
    logic [AW-1:0] hist_addr[3];

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .memory_enable     (memory_enable),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_index   (fill_word_index),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_fill(input logic [AW-1:0] base, input int n_issue, input int n_write,
                               input int busy_len);
        for (int i = 0; i < n_issue; i++) exp_addr_q.push_back(base + AW'(2 * i));
        for (int i = 0; i < n_write; i++)
            exp_wr_q.push_back({(i == N - 1), IW'(i), mem_word(base + AW'(2 * i))});
        exp_busy_q.push_back(busy_len);
    endtask

    task automatic issue_miss(input logic [AW-1:0] a);
        miss_detected = 1'b1;
        miss_address  = a;
        cyc(1);
        miss_detected = 1'b0;
    endtask

    // Memory: a request seen in cycle c is answered in cycle c+3; a reset flushes it.
    initial begin
        memory_data_valid = 1'b0;
        memory_data       = '0;
        for (int i = 0; i < 3; i++) begin
            hist_en[i]   = 1'b0;
            hist_addr[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (rst) for (int i = 0; i < 3; i++) hist_en[i] = 1'b0;
            memory_data_valid = hist_en[2] | inj_valid;
            memory_data       = hist_en[2] ? mem_word(hist_addr[2]) : (inj_valid ? inj_data : '0);
            @(negedge clk);
            hist_en[2]   = hist_en[1];
            hist_addr[2] = hist_addr[1];
            hist_en[1]   = hist_en[0];
            hist_addr[1] = hist_addr[0];
            hist_en[0]   = memory_enable;
            hist_addr[0] = memory_address;
            if (rst) for (int i = 0; i < 3; i++) hist_en[i] = 1'b0;
        end
    end

    // Monitor
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (memory_enable) begin
                if (exp_addr_q.size() == 0) check("unexpected_issue", memory_enable, 0);
                else check("issue_addr", memory_address, exp_addr_q.pop_front());
            end
            if (write_data_array) begin
                if (exp_wr_q.size() == 0) check("unexpected_write", write_data_array, 0);
                else check("write_tag_idx_data", {write_tag_array, fill_word_index, fill_data},
                           exp_wr_q.pop_front());
            end else begin
                if (write_tag_array) check("tag_without_write", write_tag_array, 0);
            end
            if (fsm_busy) begin
                run++;
            end else if (run > 0) begin
                if (exp_busy_q.size() == 0) check("unexpected_busy_len", run, 0);
                else check("busy_len", run, exp_busy_q.pop_front());
                run = 0;
            end
        end
    end

    initial begin
        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = '0;
        #2;
        check("rst_busy",  fsm_busy, 0);
        check("rst_en",    memory_enable, 0);
        check("rst_addr",  memory_address, 0);
        check("rst_wr",    write_data_array, 0);
        check("rst_idx",   fill_word_index, 0);
        check("rst_tag",   write_tag_array, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);

        // Reset asserted mid-cycle during a fill: outputs drop without a clock edge
        expect_fill(16'h0400, 1, 0, 1);
        issue_miss(16'h0404);
        cyc(1);
        #1;
        rst = 1'b1;
        #1;
        check("async_busy", fsm_busy, 0);
        check("async_en",   memory_enable, 0);
        check("async_addr", memory_address, 0);
        check("async_wr",   write_data_array, 0);
        check("async_idx",  fill_word_index, 0);
        check("async_data", fill_data, 0);
        check("async_tag",  write_tag_array, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);

        // Nominal fill
        expect_fill(16'h1230, 8, 8, 11);
        issue_miss(16'h1236);
        cyc(14);

        // Top of address space
        expect_fill(16'hFFF0, 8, 8, 11);
        issue_miss(16'hFFFA);
        cyc(14);

        // Miss held through the fill with a new address: refill after one idle cycle
        expect_fill(16'h0040, 8, 8, 11);
        expect_fill(16'h2A70, 8, 8, 11);
        miss_detected = 1'b1;
        miss_address  = 16'h0042;
        cyc(1);
        miss_address  = 16'h2A7C;
        cyc(11);
        @(negedge clk);
        check("gap_idle", fsm_busy, 0);
        cyc(1);
        miss_detected = 1'b0;
        check("refill_start", fsm_busy, 1);
        cyc(14);

        // Stray memory data while idle
        @(negedge clk);
        inj_data  = 16'hBEEF;
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        check("stray_write", write_data_array, 0);
        check("stray_tag",   write_tag_array, 0);
        @(negedge clk);
        check("stray_busy", fsm_busy, 0);
        cyc(3);

        // Reset after the third returned word, then a clean refill
        expect_fill(16'h0810, 6, 3, 6);
        issue_miss(16'h0810);
        cyc(6);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", fsm_busy, 0);
        check("abort_tag",  write_tag_array, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        expect_fill(16'h0810, 8, 8, 11);
        issue_miss(16'h0810);
        cyc(14);

        check("addr_q_drained", exp_addr_q.size(), 0);
        check("wr_q_drained",   exp_wr_q.size(), 0);
        check("busy_q_drained", exp_busy_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
